// File: rtl/perceptron_train_sched.sv
// rtl/perceptron_train_sched.sv - perceptron weight-table training scheduler
module perceptron_train_sched #(
  parameter int NR_ENTRIES = 1024,
  parameter int GHR_LENGTH = 10,
  parameter int WEIGHT_W   = 8,
  parameter int Y_W        = 12,
  parameter int THETA      = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int VLEN       = 64,
  localparam int IDX_W     = $clog2(NR_ENTRIES),
  localparam int ROW_W     = (GHR_LENGTH + 1) * WEIGHT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  debug_mode_i,
  input  logic                  lookup_valid_i,
  input  logic [IDX_W-1:0]      lookup_index_i,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [VLEN-1:0]       upd_pc_i,
  input  logic [GHR_LENGTH-1:0] upd_ghr_i,
  input  logic                  upd_taken_i,
  input  logic                  upd_mispredict_i,
  input  logic [Y_W-1:0]        upd_y_i,
  output logic                  tbl_req_o,
  output logic                  tbl_we_o,
  output logic [IDX_W-1:0]      tbl_addr_o,
  output logic [ROW_W-1:0]      tbl_wdata_o,
  input  logic [ROW_W-1:0]      tbl_rdata_i,
  output logic                  init_done_o,
  output logic                  busy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = IDX_W + GHR_LENGTH + 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NR_ENTRIES - 1);
  localparam logic [WEIGHT_W-1:0] W_MAX    = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic [WEIGHT_W-1:0] W_MIN    = {1'b1, {(WEIGHT_W-1){1'b0}}};

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CAP, S_WR} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0]      init_cnt;
  logic                  init_done_q;
  logic [ENT_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic                  fifo_empty, fifo_full, push, pop, accept, train_ok;
  logic [Y_W:0]          y_ext, y_abs;
  logic [ENT_W-1:0]      head;
  logic [IDX_W-1:0]      head_idx;
  logic [GHR_LENGTH-1:0] head_ghr;
  logic                  head_taken;
  logic [GHR_LENGTH:0]   x_pos;
  logic [ROW_W-1:0]      new_row, new_row_q;
  logic                  unused_pc;

  assign unused_pc   = ^{upd_pc_i[VLEN-1:IDX_W+1], upd_pc_i[0]};
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // A retiring write frees its slot in the same cycle, so a full FIFO can still accept.
  assign pop         = (state == S_WR) && !lookup_valid_i;
  assign upd_ready_o = !rst_i && init_done_q && (!fifo_full || pop);
  assign accept      = upd_valid_i && upd_ready_o;
  // |y| needs one extra bit so the most negative y does not wrap.
  assign y_ext       = {upd_y_i[Y_W-1], upd_y_i};
  assign y_abs       = upd_y_i[Y_W-1] ? (~y_ext + (Y_W+1)'(1)) : y_ext;
  assign train_ok    = upd_mispredict_i || (y_abs <= (Y_W+1)'(THETA));
  assign push        = accept && !debug_mode_i && train_ok;
  assign head        = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign {head_idx, head_ghr, head_taken} = head;
  // Bias input is constant +1; history bit i drives input i+1.
  assign x_pos       = {head_ghr, 1'b1};

  // FIFO pointers; reset discards everything queued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // FIFO storage: row index, history and resolved direction.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {upd_pc_i[IDX_W:1], upd_ghr_i, upd_taken_i};
  end

  // Zero-sweep address counter; it only moves on cycles the frontend leaves free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_cnt    <= '0;
      init_done_q <= 1'b0;
    end else if (state == S_INIT && !lookup_valid_i) begin
      init_cnt <= init_cnt + IDX_W'(1);
      if (init_cnt == LAST_IDX) init_done_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_INIT;
    else       state <= state_nxt;
  end

  // Saturating +/-1 on every weight: +1 when direction and input agree.
  always_comb begin
    new_row = '0;
    for (int k = 0; k <= GHR_LENGTH; k++) begin
      if (x_pos[k] == head_taken)
        new_row[k*WEIGHT_W +: WEIGHT_W] = (tbl_rdata_i[k*WEIGHT_W +: WEIGHT_W] == W_MAX) ?
            W_MAX : tbl_rdata_i[k*WEIGHT_W +: WEIGHT_W] + WEIGHT_W'(1);
      else
        new_row[k*WEIGHT_W +: WEIGHT_W] = (tbl_rdata_i[k*WEIGHT_W +: WEIGHT_W] == W_MIN) ?
            W_MIN : tbl_rdata_i[k*WEIGHT_W +: WEIGHT_W] - WEIGHT_W'(1);
    end
  end

  // Capture the updated row once; later rdata changes must not disturb a deferred write.
  always_ff @(posedge clk_i) begin
    if (rst_i)               new_row_q <= '0;
    else if (state == S_CAP) new_row_q <= new_row;
  end

  // Next state and table-port mux; lookups override, reset silences the port.
  always_comb begin
    state_nxt   = state;
    tbl_req_o   = 1'b0;
    tbl_we_o    = 1'b0;
    tbl_addr_o  = '0;
    tbl_wdata_o = '0;
    case (state)
      S_INIT: if (!lookup_valid_i) begin
        tbl_req_o  = 1'b1;
        tbl_we_o   = 1'b1;
        tbl_addr_o = init_cnt;
        if (init_cnt == LAST_IDX) state_nxt = S_IDLE;
      end
      S_IDLE: if (!fifo_empty) state_nxt = S_RD;
      S_RD: if (!lookup_valid_i) begin
        tbl_req_o  = 1'b1;
        tbl_addr_o = head_idx;
        state_nxt  = S_CAP;
      end
      S_CAP: state_nxt = S_WR;
      S_WR: if (!lookup_valid_i) begin
        tbl_req_o   = 1'b1;
        tbl_we_o    = 1'b1;
        tbl_addr_o  = head_idx;
        tbl_wdata_o = new_row_q;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
    if (lookup_valid_i) begin
      tbl_req_o   = 1'b1;
      tbl_we_o    = 1'b0;
      tbl_addr_o  = lookup_index_i;
      tbl_wdata_o = '0;
    end
    if (rst_i) begin
      tbl_req_o   = 1'b0;
      tbl_we_o    = 1'b0;
      tbl_addr_o  = '0;
      tbl_wdata_o = '0;
    end
  end

  assign busy_o      = rst_i || !fifo_empty || (state != S_IDLE);
  assign init_done_o = init_done_q && !rst_i;

endmodule

// File: tb/tb_perceptron_train_sched.sv
// tb/tb_perceptron_train_sched.sv - randomized self-checking bench for perceptron_train_sched
module tb_perceptron_train_sched;
  localparam int NR = 1024, GHR = 10, ROW_W = 88, THETA = 20;

  logic clk = 1'b0;
  logic rst, debug_mode, lookup_valid, upd_valid, upd_ready, upd_taken, upd_mispredict;
  logic [9:0] lookup_index, upd_ghr, tbl_addr;
  logic [63:0] upd_pc;
  logic [11:0] upd_y;
  logic tbl_req, tbl_we, init_done, busy;
  logic [ROW_W-1:0] tbl_wdata, tbl_rdata;

  perceptron_train_sched dut (
    .clk_i(clk), .rst_i(rst), .debug_mode_i(debug_mode),
    .lookup_valid_i(lookup_valid), .lookup_index_i(lookup_index),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_pc_i(upd_pc),
    .upd_ghr_i(upd_ghr), .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict),
    .upd_y_i(upd_y), .tbl_req_o(tbl_req), .tbl_we_o(tbl_we), .tbl_addr_o(tbl_addr),
    .tbl_wdata_o(tbl_wdata), .tbl_rdata_i(tbl_rdata), .init_done_o(init_done), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int c; logic [9:0] a; logic [ROW_W-1:0] d;} wr_t;
  typedef struct {int idx; logic [9:0] g; bit t;} req_t;

  int cyc = 0;
  int vectors = 0, miscompares = 0;
  bit rand_lk = 0;
  logic [ROW_W-1:0] mem [NR];
  wr_t  wlog [$];
  req_t expq [$];
  int   ref_w [NR][GHR+1];

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port weight SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (tbl_req === 1'b1 && tbl_we === 1'b1) mem[tbl_addr] <= tbl_wdata;
    else if (tbl_req === 1'b1) tbl_rdata <= mem[tbl_addr];
  end

  // Log every table write with its cycle.
  always @(negedge clk) begin
    if (tbl_req === 1'b1 && tbl_we === 1'b1) wlog.push_back('{cyc, tbl_addr, tbl_wdata});
  end

  task automatic model_clear();
    for (int i = 0; i < NR; i++) for (int k = 0; k <= GHR; k++) ref_w[i][k] = 0;
  endtask

  // Reference perceptron rule: w_k += t*x_k, clamped to the 8-bit signed range.
  function automatic logic [ROW_W-1:0] model_train(req_t r);
    logic [ROW_W-1:0] row;
    int v, x, t;
    t = r.t ? 1 : -1;
    for (int k = 0; k <= GHR; k++) begin
      x = (k == 0) ? 1 : (r.g[k-1] ? 1 : -1);
      v = ref_w[r.idx][k] + t * x;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      ref_w[r.idx][k] = v;
      row[k*8 +: 8] = v[7:0];
    end
    return row;
  endfunction

  function automatic bit qualifies(bit m, logic [11:0] yy);
    int v = int'($signed(yy));
    return m || (v <= THETA && v >= -THETA);
  endfunction

  function automatic logic [63:0] mkpc(int idx);
    return {53'({$urandom(), $urandom()}), 10'(idx), 1'($urandom())};
  endfunction

  task automatic preload(input int idx, input logic [ROW_W-1:0] row);
    mem[idx] <= row;
    for (int k = 0; k <= GHR; k++) ref_w[idx][k] = int'($signed(row[k*8 +: 8]));
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rand_lk) begin
      lookup_valid = ($urandom_range(0, 2) == 0);
      lookup_index = 10'($urandom());
    end
  endtask

  task automatic send(input logic [63:0] p, input logic [9:0] g, input bit t, input bit m,
                      input logic [11:0] yy, input bit dbg, output int e, output bit ok);
    upd_pc = p; upd_ghr = g; upd_taken = t; upd_mispredict = m; upd_y = yy;
    debug_mode = dbg; upd_valid = 1'b1; ok = 0; e = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (upd_ready === 1'b1) begin ok = 1; e = cyc; end
      tick();
    end
    upd_valid = 1'b0; debug_mode = 1'b0;
    if (!ok) begin miscompares++; $display("FAIL send_timeout: ready never seen, want accept"); end
    if (ok && !dbg && qualifies(m, yy)) expq.push_back('{int'(p[10:1]), g, t});
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1;
      tick();
    end
  endtask

  task automatic test_reset();
    bit done = 0; int bad = 0; logic rdy, bsy;
    rst = 1'b1; repeat (3) @(posedge clk); @(negedge clk);
    vectors += 7;
    if (tbl_req !== 1'b0)   begin miscompares++; $display("FAIL reset_req: got %b want 0", tbl_req); end
    if (tbl_we !== 1'b0)    begin miscompares++; $display("FAIL reset_we: got %b want 0", tbl_we); end
    if (tbl_addr !== 10'd0) begin miscompares++; $display("FAIL reset_addr: got %0h want 0", tbl_addr); end
    if (tbl_wdata !== '0)   begin miscompares++; $display("FAIL reset_wdata: got %0h want 0", tbl_wdata); end
    if (upd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", upd_ready); end
    if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", init_done); end
    if (busy !== 1'b1)      begin miscompares++; $display("FAIL reset_busy: got %b want 1", busy); end
    @(posedge clk); #1; rst = 1'b0; wlog.delete();
    for (int i = 0; i < NR + 100 && !done; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin done = 1; rdy = upd_ready; bsy = busy; end
      tick();
    end
    vectors += 5;
    if (!done) begin miscompares++; $display("FAIL sweep_done: got 0 want 1"); end
    if (wlog.size() != NR) begin miscompares++; $display("FAIL sweep_count: got %0d want %0d", wlog.size(), NR); end
    foreach (wlog[i]) if (wlog[i].a !== 10'(i) || wlog[i].d !== '0) bad++;
    if (bad != 0) begin miscompares++; $display("FAIL sweep_rows: got %0d bad want 0", bad); end
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL sweep_ready: got %b want 1", rdy); end
    if (bsy !== 1'b0) begin miscompares++; $display("FAIL sweep_busy: got %b want 0", bsy); end
    model_clear(); wlog.delete();
  endtask

  task automatic test_single();
    int e; bit ok; logic [ROW_W-1:0] want, m;
    want = {{9{8'hFF}}, 8'h01, 8'h01};
    wlog.delete();
    send(64'h104, 10'b0000000001, 1'b1, 1'b1, 12'd0, 1'b0, e, ok);
    wait_idle(40, ok);
    vectors += 1;
    if (wlog.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", wlog.size()); end
    else begin
      m = model_train(expq.pop_front());
      vectors += 4;
      if (wlog[0].a !== 10'h82) begin miscompares++; $display("FAIL single_addr: got %0h want 82", wlog[0].a); end
      if (wlog[0].d !== want) begin miscompares++; $display("FAIL single_row: got %0h want %0h", wlog[0].d, want); end
      if (wlog[0].d !== m) begin miscompares++; $display("FAIL single_model: got %0h want %0h", wlog[0].d, m); end
      if (wlog[0].c - e != 4) begin miscompares++; $display("FAIL single_latency: got %0d want 4", wlog[0].c - e); end
    end
    expq.delete(); wlog.delete();
  endtask

  task automatic test_filter();
    int yn[2] = '{25, -21}; int e; bit ok, saw; logic [ROW_W-1:0] m;
    for (int j = 0; j < 2; j++) begin
      wlog.delete(); saw = 0;
      send(mkpc($urandom_range(0, NR-1)), 10'($urandom()), 1'($urandom()), 1'b0, 12'(yn[j]), 1'b0, e, ok);
      for (int i = 0; i < 12; i++) begin @(negedge clk); if (busy === 1'b1) saw = 1; tick(); end
      vectors += 2;
      if (saw) begin miscompares++; $display("FAIL filter_busy y=%0d: got 1 want 0", yn[j]); end
      if (wlog.size() != 0) begin miscompares++; $display("FAIL filter_write y=%0d: got %0d want 0", yn[j], wlog.size()); end
    end
    wlog.delete();
    send(mkpc($urandom_range(0, NR-1)), 10'($urandom()), 1'($urandom()), 1'b0, 12'hFEC, 1'b0, e, ok);
    wait_idle(40, ok);
    vectors += 1;
    if (wlog.size() != 1 || expq.size() != 1) begin
      miscompares++; $display("FAIL filter_train: got %0d writes want 1", wlog.size());
    end else begin
      req_t r = expq.pop_front();
      m = model_train(r);
      vectors += 1;
      if (wlog[0].a !== 10'(r.idx) || wlog[0].d !== m)
        begin miscompares++; $display("FAIL filter_row: got %0h@%0h want %0h@%0h", wlog[0].d, wlog[0].a, m, r.idx); end
    end
    expq.delete(); wlog.delete();
  endtask

  task automatic test_saturation();
    int e, idx; bit ok; logic [ROW_W-1:0] row, m;
    for (int s = 0; s < 2; s++) begin
      idx = $urandom_range(0, NR-1);
      for (int k = 0; k <= GHR; k++) row[k*8 +: 8] = 8'($urandom());
      row[7:0] = (s == 0) ? 8'h7F : 8'h80;
      preload(idx, row); wlog.delete(); tick();
      send(mkpc(idx), 10'($urandom()), (s == 0), 1'b1, 12'($urandom()), 1'b0, e, ok);
      wait_idle(40, ok);
      vectors += 1;
      if (wlog.size() != 1) begin miscompares++; $display("FAIL sat_count s=%0d: got %0d want 1", s, wlog.size()); end
      else begin
        m = model_train(expq.pop_front());
        vectors += 2;
        if (wlog[0].d !== m) begin miscompares++; $display("FAIL sat_row s=%0d: got %0h want %0h", s, wlog[0].d, m); end
        if (wlog[0].d[7:0] !== row[7:0]) begin miscompares++; $display("FAIL sat_bias s=%0d: got %0h want %0h", s, wlog[0].d[7:0], row[7:0]); end
      end
      expq.delete();
    end
    wlog.delete();
  endtask

  task automatic test_collision();
    int e, idx; bit ok; logic [ROW_W-1:0] row, m;
    idx = $urandom_range(0, NR-1);
    for (int k = 0; k <= GHR; k++) row[k*8 +: 8] = 8'($urandom());
    preload(idx, row); wlog.delete(); tick();
    send(mkpc(idx), 10'($urandom()), 1'($urandom()), 1'b1, 12'd0, 1'b0, e, ok);
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 6; i++) begin
        lookup_valid = 1'b1; lookup_index = 10'($urandom());
        @(negedge clk);
        vectors++;
        if (tbl_req !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== lookup_index)
          begin miscompares++; $display("FAIL collide_lookup: got %b%b@%0h want 10@%0h", tbl_req, tbl_we, tbl_addr, lookup_index); end
        @(posedge clk); #1;
      end
      lookup_valid = 1'b0;
      if (ph == 0) begin
        @(negedge clk);
        vectors++;
        if (tbl_req !== 1'b1 || tbl_we !== 1'b0 || tbl_addr !== 10'(idx))
          begin miscompares++; $display("FAIL collide_read: got %b%b@%0h want 10@%0h", tbl_req, tbl_we, tbl_addr, idx); end
        @(posedge clk); #1;
      end
    end
    wait_idle(40, ok);
    vectors += 1;
    if (wlog.size() != 1) begin miscompares++; $display("FAIL collide_count: got %0d want 1", wlog.size()); end
    else begin
      m = model_train(expq.pop_front());
      vectors += 2;
      if (wlog[0].d !== m) begin miscompares++; $display("FAIL collide_row: got %0h want %0h", wlog[0].d, m); end
      if (wlog[0].c - e != 14) begin miscompares++; $display("FAIL collide_cycle: got %0d want 14", wlog[0].c - e); end
    end
    expq.delete(); wlog.delete();
  endtask

  task automatic test_debug();
    int e; bit ok, saw = 0;
    wlog.delete();
    send(mkpc($urandom_range(0, NR-1)), 10'($urandom()), 1'b1, 1'b1, 12'd0, 1'b1, e, ok);
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (busy === 1'b1) saw = 1; tick(); end
    vectors += 3;
    if (!ok) begin miscompares++; $display("FAIL debug_accept: got 0 want 1"); end
    if (saw) begin miscompares++; $display("FAIL debug_busy: got 1 want 0"); end
    if (wlog.size() != 0) begin miscompares++; $display("FAIL debug_write: got %0d want 0", wlog.size()); end
    wlog.delete();
  endtask

  task automatic test_backpressure();
    int acc = 0; int rows[2]; bit ok, took; logic rdy_end; req_t r; wr_t w; logic [ROW_W-1:0] m;
    rows[0] = $urandom_range(0, NR-1); rows[1] = $urandom_range(0, NR-1);
    wlog.delete(); rand_lk = 0;
    lookup_valid = 1'b1; lookup_index = 10'($urandom());
    upd_pc = mkpc(rows[$urandom_range(0, 1)]); upd_ghr = 10'($urandom()); upd_taken = 1'($urandom());
    upd_mispredict = 1'b1; upd_y = 12'($urandom()); upd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      took = (upd_ready === 1'b1) && upd_valid;
      if (took) begin expq.push_back('{int'(upd_pc[10:1]), upd_ghr, upd_taken}); acc++; end
      @(posedge clk); #1;
      lookup_index = 10'($urandom());
      if (took) begin
        upd_pc = mkpc(rows[$urandom_range(0, 1)]); upd_ghr = 10'($urandom()); upd_taken = 1'($urandom());
        if (acc == 6) upd_valid = 1'b0;
      end
    end
    upd_valid = 1'b0;
    @(negedge clk); rdy_end = upd_ready;
    vectors += 2;
    if (acc != 4) begin miscompares++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    if (rdy_end !== 1'b0) begin miscompares++; $display("FAIL bp_ready: got %b want 0", rdy_end); end
    @(posedge clk); #1; lookup_valid = 1'b0;
    wait_idle(200, ok);
    vectors += 1;
    if (wlog.size() != expq.size()) begin miscompares++; $display("FAIL bp_count: got %0d want %0d", wlog.size(), expq.size()); end
    while (expq.size() > 0 && wlog.size() > 0) begin
      r = expq.pop_front(); w = wlog.pop_front(); m = model_train(r);
      vectors++;
      if (w.a !== 10'(r.idx) || w.d !== m) begin miscompares++; $display("FAIL bp_order: got %0h@%0h want %0h@%0h", w.d, w.a, m, r.idx); end
    end
    expq.delete(); wlog.delete();
  endtask

  task automatic test_random();
    int e; bit ok; req_t r; wr_t w; logic [ROW_W-1:0] m;
    wlog.delete(); rand_lk = 1;
    for (int n = 0; n < 40; n++) begin
      send(mkpc($urandom_range(0, 7)), 10'($urandom()), 1'($urandom()), ($urandom_range(0, 3) == 0),
           12'(int'($urandom_range(0, 80)) - 40), 1'b0, e, ok);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle(3000, ok);
    rand_lk = 0; lookup_valid = 1'b0;
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL rand_idle: busy got 1 want 0"); end
    if (wlog.size() != expq.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", wlog.size(), expq.size()); end
    while (expq.size() > 0 && wlog.size() > 0) begin
      r = expq.pop_front(); w = wlog.pop_front(); m = model_train(r);
      vectors++;
      if (w.a !== 10'(r.idx) || w.d !== m) begin miscompares++; $display("FAIL rand_row: got %0h@%0h want %0h@%0h", w.d, w.a, m, r.idx); end
    end
    expq.delete(); wlog.delete();
  endtask

  task automatic test_reset_midflight();
    int e, n = 0, nl = 0; bit ok, done = 0; logic bsy;
    send(mkpc($urandom_range(0, NR-1)), 10'($urandom()), 1'b1, 1'b1, 12'd0, 1'b0, e, ok);
    tick();
    rst = 1'b1; rand_lk = 1;
    tick(); tick(); tick();
    rst = 1'b0;
    expq.delete(); model_clear();
    for (int i = 0; i < 2 * NR + 100 && !done; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) begin done = 1; bsy = busy; end
      else begin n++; if (lookup_valid) nl++; end
      tick();
    end
    rand_lk = 0; lookup_valid = 1'b0; wlog.delete();
    repeat (10) tick();
    vectors += 4;
    if (!done) begin miscompares++; $display("FAIL mid_done: got 0 want 1"); end
    if (n != NR + nl) begin miscompares++; $display("FAIL mid_duration: got %0d want %0d", n, NR + nl); end
    if (bsy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", bsy); end
    if (wlog.size() != 0) begin miscompares++; $display("FAIL mid_lost: got %0d writes want 0", wlog.size()); end
  endtask

  initial begin
    rst = 1'b1; debug_mode = 1'b0; lookup_valid = 1'b0; lookup_index = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
    upd_mispredict = 1'b0; upd_y = '0;
    test_reset();
    test_single();
    test_filter();
    test_saturation();
    test_collision();
    test_debug();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
